lcd_ctrl: RTL

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/singlecycle_pkg.sv | 36 +++
 rtl/lcd_fifo.sv | 62 ++++++
 rtl/lcd_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/singlecycle_pkg.sv
// Shared types and field constants for the LCD store-port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: lcd_state_e FSM encoding, lcd_word_t (RS + DATA), LSU word field
// positions, clear/home command codes and counter-load helpers.
package singlecycle_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } lcd_state_e;

  // One buffered panel write: register-select plus data byte.
  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
  } lcd_word_t;

  localparam int         LCD_ON_BIT   = 31;
  localparam int         LCD_RS_BIT   = 8;
  localparam logic [7:0] LCD_CLR_CMD  = 8'h01;
  localparam logic [7:0] LCD_HOME_CMD = 8'h02;

  // Down-counter load for an N-cycle state; N=0 still occupies one cycle.
  function automatic int unsigned cyc_load(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO holding pending panel writes.
// Latency: a pushed entry is visible on rd_dat/rd_vld the cycle after the push.
// Backpressure: wr_rdy drops when full; pushes while full are ignored.
// Ports: i_clk/i_rst_n (sync active-low), wr_vld/wr_dat/wr_rdy write side,
// rd_vld/rd_dat/rd_rdy read side (rd_rdy pops the head entry).
module lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  assign wr_rdy = (cnt != (AW+1)'(DEPTH));
  assign rd_vld = (cnt != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt alone.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style write-only panel driver fed by LSU store words.
// Latency: EN rises T_SETUP_CYC+1 cycles after the accepting edge.
// Backpressure: o_lcd_rdy low while no room; a strobe without rdy is dropped and sets sticky o_lcd_ovf.
// Build option: define LCD_FIFO_EN for a 4-entry input FIFO; otherwise a single slot.
// Ports: i_clk, i_rst_n (sync active-low); i_lcd_data/i_lcd_vld/o_lcd_rdy store
// input ([31]=ON, [8]=RS, [7:0]=DATA); o_lcd_busy, o_lcd_ovf status;
// o_lcd_on/en/rs/rw/dat panel pins.
module lcd_ctrl
  import singlecycle_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_PW_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 1,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_CLR_CYC   = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_data,
  input  logic        i_lcd_vld,
  output logic        o_lcd_rdy,
  output logic        o_lcd_busy,
  output logic        o_lcd_ovf,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_dat
);

  localparam int unsigned CNT_MAX = max_u(max_u(max_u(T_SETUP_CYC, T_PW_CYC),
                                                max_u(T_HOLD_CYC, T_EXEC_CYC)),
                                          T_CLR_CYC);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(cyc_load(T_SETUP_CYC));
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(cyc_load(T_PW_CYC));
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(cyc_load(T_HOLD_CYC));
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(cyc_load(T_EXEC_CYC));
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(cyc_load(T_CLR_CYC));

  lcd_state_e       state_q;
  lcd_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             run_q;      // low during reset and the first cycle after it
  logic             lcd_en_q;
  logic             lcd_rs_q;
  logic [7:0]       lcd_dat_q;
  logic             lcd_on_q;
  logic             lcd_ovf_q;

  logic             lcd_rdy;
  logic             accept;
  logic             take;       // IDLE consumes the pending word this cycle
  logic             word_vld;
  lcd_word_t        word;
  lcd_word_t        word_in;
  logic             slow_cmd;
  logic             unused_bits;

  // ---------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------
  assign word_in     = '{rs: i_lcd_data[LCD_RS_BIT], dat: i_lcd_data[7:0]};
  assign unused_bits = ^i_lcd_data[30:9];
  assign accept      = i_lcd_vld && lcd_rdy;

  // ---------------------------------------------------------------
  // Input buffering
  // ---------------------------------------------------------------
`ifdef LCD_FIFO_EN
  logic fifo_wr_rdy;

  lcd_fifo #(
    .DEPTH (4),
    .WIDTH ($bits(lcd_word_t))
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_vld  (accept),
    .wr_dat  (word_in),
    .wr_rdy  (fifo_wr_rdy),
    .rd_vld  (word_vld),
    .rd_dat  (word),
    .rd_rdy  (take)
  );

  assign lcd_rdy = run_q && fifo_wr_rdy;
`else
  logic      slot_vld_q;
  lcd_word_t slot_q;

  // The slot stays occupied for the one IDLE cycle before SETUP, so rdy
  // also waits for it to drain; otherwise a second word could overwrite it.
  assign lcd_rdy  = run_q && (state_q == IDLE) && !slot_vld_q;
  assign word_vld = slot_vld_q;
  assign word     = slot_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
    end else if (accept) begin
      slot_vld_q <= 1'b1;
      slot_q     <= word_in;
    end else if (take) begin
      slot_vld_q <= 1'b0;
    end
  end
`endif

  // Clear (0x01) and home (0x02/0x03) share the long execution time.
  assign slow_cmd = !lcd_rs_q &&
                    ((lcd_dat_q[7:1] == LCD_CLR_CMD[7:1]) ||
                     (lcd_dat_q[7:1] == LCD_HOME_CMD[7:1]));

  // ---------------------------------------------------------------
  // FSM: next state and counter
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (word_vld) begin
          take    = 1'b1;
          state_d = SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = LD_PW;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = slow_cmd ? LD_CLR : LD_EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      lcd_en_q  <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_dat_q <= 8'h00;
      lcd_on_q  <= 1'b0;
      lcd_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= 1'b1;
      // EN registered from the next state so the pin is glitch-free.
      lcd_en_q <= (state_d == PULSE);
      if (take) begin
        lcd_rs_q  <= word.rs;
        lcd_dat_q <= word.dat;
      end
      if (accept) begin
        lcd_on_q <= i_lcd_data[LCD_ON_BIT];
      end
      if (i_lcd_vld && !lcd_rdy) begin
        lcd_ovf_q <= 1'b1;
      end
    end
  end

  assign o_lcd_rdy  = lcd_rdy;
  assign o_lcd_busy = (state_q != IDLE);
  assign o_lcd_ovf  = lcd_ovf_q;
  assign o_lcd_on   = lcd_on_q;
  assign o_lcd_en   = lcd_en_q;
  assign o_lcd_rs   = lcd_rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_dat  = lcd_dat_q;

endmodule
